// File: rtl/tdc_calib_pkg.sv
// Shared state encodings and width helpers for the TDC calibration sequencer.
// Optional abort support is enabled with the TDC_CALIB_ABORT_EN macro (see tdc_calib_ctrl).
package tdc_calib_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ACC    = 3'd3;
    localparam logic [2:0] ST_EVAL   = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Sum of 2**log2_samples samples of hw_w bits never overflows this width.
    function automatic int acc_width(input int hw_w, input int log2_samples);
        return hw_w + log2_samples;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdc_calib_acc.sv
// Sample counter and accumulator for one SAR trial; full_o flags the cycle in
// which the last sample of the set is accepted.
module tdc_calib_acc
    import tdc_calib_pkg::*;
#(
    parameter int HW_W         = 7,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [HW_W-1:0] smp,
    output logic            full_o,
    output logic [HW_W-1:0] mean_o
);

    localparam int AW = acc_width(HW_W, LOG2_SAMPLES);

    logic [AW-1:0]           acc;
    logic [LOG2_SAMPLES-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            acc <= acc + {{LOG2_SAMPLES{1'b0}}, smp};
            cnt <= cnt + 1'b1;
        end
    end

    assign full_o = en && (cnt == '1);
    assign mean_o = acc[AW-1:LOG2_SAMPLES];

endmodule

// File: rtl/tdc_calib_ctrl.sv
// SAR calibration sequencer: finds, per sensor, the largest delay code whose mean sample
// stays <= target. Define TDC_CALIB_ABORT_EN to add the abort_i / aborted_o ports.
module tdc_calib_ctrl
    import tdc_calib_pkg::*;
#(
    parameter int N_TDC        = 16,
    parameter int DLY_W        = 8,
    parameter int HW_W         = 7,
    parameter int LOG2_SAMPLES = 4,
    parameter int SETTLE_CYC   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [HW_W-1:0]             target_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [sel_width(N_TDC)-1:0] sel_o,
    output logic [DLY_W-1:0]            dly_code_o,
    output logic                        dly_we_o,
    input  logic [HW_W-1:0]             smp_i,
    input  logic                        smp_vld_i
`ifdef TDC_CALIB_ABORT_EN
    ,
    input  logic                        abort_i,
    output logic                        aborted_o
`endif
);

    localparam int SEL_W = sel_width(N_TDC);
    localparam int STL_W = sel_width(SETTLE_CYC);
    localparam logic [DLY_W-1:0] BIT_MSB = {1'b1, {(DLY_W-1){1'b0}}};

    logic [2:0]       state;
    logic [HW_W-1:0]  target;
    logic [DLY_W-1:0] code;
    logic [DLY_W-1:0] bit_mask;
    logic [STL_W-1:0] settle_cnt;
    logic [SEL_W-1:0] sel;
    logic             abort;
    logic             acc_clr;
    logic             acc_en;
    logic             acc_full;
    logic [HW_W-1:0]  mean;

`ifdef TDC_CALIB_ABORT_EN
    logic aborted;

    assign abort = abort_i && (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) aborted <= 1'b0;
        else       aborted <= abort;
    end

    assign aborted_o = aborted;
`else
    assign abort = 1'b0;
`endif

    assign acc_clr = (state == ST_EVAL) || (state == ST_IDLE);
    assign acc_en  = (state == ST_ACC) && smp_vld_i;

    tdc_calib_acc #(
        .HW_W        (HW_W),
        .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_acc (
        .clock (clock),
        .reset (reset),
        .clr   (acc_clr),
        .en    (acc_en),
        .smp   (smp_i),
        .full_o(acc_full),
        .mean_o(mean)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            target     <= '0;
            code       <= '0;
            bit_mask   <= '0;
            settle_cnt <= '0;
            sel        <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        target   <= target_i;
                        sel      <= '0;
                        code     <= '0;
                        bit_mask <= BIT_MSB;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == STL_W'(SETTLE_CYC - 1)) state <= ST_ACC;
                    else                                      settle_cnt <= settle_cnt + 1'b1;
                end
                ST_ACC: begin
                    if (acc_full) state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (mean <= target) code <= code | bit_mask;
                    if (bit_mask[0]) begin
                        state <= ST_COMMIT;
                    end else begin
                        bit_mask <= bit_mask >> 1;
                        state    <= ST_WRITE;
                    end
                end
                ST_COMMIT: begin
                    if (sel == SEL_W'(N_TDC - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        sel      <= sel + 1'b1;
                        code     <= '0;
                        bit_mask <= BIT_MSB;
                        state    <= ST_WRITE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Write strobe and done are gated by a same-cycle abort so it wins over COMMIT/DONE.
    always_comb begin
        dly_code_o = '0;
        if (state == ST_WRITE)       dly_code_o = code | bit_mask;
        else if (state == ST_COMMIT) dly_code_o = code;
    end

    assign dly_we_o = ((state == ST_WRITE) || (state == ST_COMMIT)) && !abort;
    assign done_o   = (state == ST_DONE) && !abort;
    assign busy_o   = (state != ST_IDLE) && (state != ST_DONE);
    assign sel_o    = sel;

endmodule

// File: tb/tb_tdc_calib_ctrl.sv
// Self-checking bench for tdc_calib_ctrl with a 4-sensor bank model (sample = code >> 2).
// Abort scenarios are compiled in when TDC_CALIB_ABORT_EN is defined.
module tb_tdc_calib_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int HW  = 7;
    localparam int L   = 4;
    localparam int SC  = 8;
    localparam int SW  = 2;
    localparam int WPS = DW + 1;
    localparam int LAT = N * (DW * (1 + SC + (1 << L) + 1) + 1) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [HW-1:0] target_i = '0;
    logic [HW-1:0] smp_i = '0;
    logic          smp_vld_i = 1'b1;
    logic          busy_o, done_o, dly_we_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dly_code_o;
`ifdef TDC_CALIB_ABORT_EN
    logic          abort_i = 1'b0;
    logic          aborted_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] bank [N];
    logic [DW-1:0] wr_code [$];
    logic [SW-1:0] wr_sel [$];
    logic [DW-1:0] exp_q [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int aborted_cnt = 0;
    int start_cyc = 0;
    int vld_mode = 0;
    int force_sensor = -1;
    bit inj_settle = 1'b0;
    int settle_left = 0;

    tdc_calib_ctrl #(
        .N_TDC(N), .DLY_W(DW), .HW_W(HW), .LOG2_SAMPLES(L), .SETTLE_CYC(SC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start_i   (start_i),
        .target_i  (target_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sel_o     (sel_o),
        .dly_code_o(dly_code_o),
        .dly_we_o  (dly_we_o),
        .smp_i     (smp_i),
        .smp_vld_i (smp_vld_i)
`ifdef TDC_CALIB_ABORT_EN
        ,
        .abort_i   (abort_i),
        .aborted_o (aborted_o)
`endif
    );

    // Clock and cycle count
    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    // Bank model and observer: capture writes, then drive the selected sensor's sample.
    always @(negedge clock) begin
        bit in_settle;
        if (reset === 1'b0) begin
            in_settle = (settle_left > 0);
            if (in_settle) settle_left--;
            if (dly_we_o === 1'b1) begin
                bank[sel_o] = dly_code_o;
                wr_code.push_back(dly_code_o);
                wr_sel.push_back(sel_o);
                settle_left = SC;
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
`ifdef TDC_CALIB_ABORT_EN
            if (aborted_o === 1'b1) aborted_cnt++;
`endif
            if (in_settle && inj_settle) begin
                smp_i     = 7'h7F;
                smp_vld_i = 1'b1;
            end else begin
                case (vld_mode)
                    0:       smp_vld_i = 1'b1;
                    1:       smp_vld_i = cyc[0];
                    default: smp_vld_i = 1'($urandom_range(0, 1));
                endcase
                if (force_sensor == int'(sel_o)) smp_i = 7'h7F;
                else                             smp_i = 7'(bank[sel_o] >> 2);
            end
        end
    end

    // Reference: largest code whose constant sample value is <= target, else 0.
    function automatic logic [DW-1:0] exp_code(input int tgt, input bit forced);
        int best = 0;
        for (int c = 0; c < (1 << DW); c++) begin
            int s = forced ? 127 : (c >> 2);
            if (s <= tgt) best = c;
        end
        return DW'(best);
    endfunction

    task automatic clear_log();
        wr_code.delete();
        wr_sel.delete();
        exp_q.delete();
        done_cnt = 0;
        aborted_cnt = 0;
    endtask

    task automatic pulse_start(input int tgt);
        @(posedge clock); #1;
        start_i   = 1'b1;
        target_i  = HW'(tgt);
        start_cyc = cyc;
        @(posedge clock); #1;
        start_i   = 1'b0;
        target_i  = HW'($urandom_range(0, 127));
    endtask

    // Full run from start to done, checking commits, sel ordering, latency and done pulse.
    task automatic run_and_check(input string name, input int tgt, input int vmode,
                                 input int fsens, input bit inj, input bit repulse);
        logic [DW-1:0] got;
        clear_log();
        vld_mode     = vmode;
        force_sensor = fsens;
        inj_settle   = inj;
        for (int s = 0; s < N; s++) exp_q.push_back(exp_code(tgt, s == fsens));
        pulse_start(tgt);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            @(posedge clock); #1;
            start_i = repulse && (i == 300);
            if (start_i) target_i = HW'($urandom_range(0, 127));
        end
        start_i = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_count got %0d exp 1", name, done_cnt);
        end
        checks++;
        if (wr_code.size() !== N * WPS) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", name, wr_code.size(), N * WPS);
        end else begin
            for (int k = 0; k < N * WPS; k++) begin
                checks++;
                if (wr_sel[k] !== SW'(k / WPS)) begin
                    errors++;
                    $display("FAIL %s sel_at_write%0d got %0d exp %0d", name, k, wr_sel[k], k / WPS);
                end
            end
            for (int s = 0; s < N; s++) begin
                got = wr_code[s * WPS + DW];
                checks++;
                if (got !== exp_q[s]) begin
                    errors++;
                    $display("FAIL %s commit_s%0d got %h exp %h", name, s, got, exp_q[s]);
                end
            end
        end
        if (done_cnt > 0) begin
            checks++;
            if (vmode == 0 && (done_cyc - start_cyc) != LAT) begin
                errors++;
                $display("FAIL %s latency got %0d exp %0d", name, done_cyc - start_cyc, LAT);
            end else if (vmode != 0 && (done_cyc - start_cyc) <= LAT) begin
                errors++;
                $display("FAIL %s stalled_latency got %0d exp >%0d", name, done_cyc - start_cyc, LAT);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done got %b exp 0", name, busy_o);
        end
        vld_mode = 0; force_sensor = -1; inj_settle = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({busy_o, done_o, sel_o, dly_code_o, dly_we_o} !== '0) begin
            errors++;
            $display("FAIL %s outputs got busy=%b done=%b sel=%0d code=%h we=%b exp all 0",
                     name, busy_o, done_o, sel_o, dly_code_o, dly_we_o);
        end
    endtask

    task automatic wait_writes(input string name, input int n);
        int i;
        for (i = 0; i < 20000 && wr_code.size() < n; i++) @(posedge clock);
        if (wr_code.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s wait_writes got %0d exp %0d", name, wr_code.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset_held");
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("idle_no_start");
    endtask

    task automatic test_reset_mid_run();
        clear_log();
        pulse_start(20);
        wait_writes("reset_mid_run", WPS + 1);
        repeat (SC + 3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset_mid_run");
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (30) @(posedge clock);
        @(negedge clock);
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d exp 0", done_cnt);
        end
        check_outputs_zero("after_reset_idle");
    endtask

`ifdef TDC_CALIB_ABORT_EN
    task automatic abort_pulse();
        @(posedge clock); #1;
        abort_i = 1'b1;
        @(posedge clock); #1;
        abort_i = 1'b0;
    endtask

    task automatic check_abort(input string name, input int exp_writes);
        repeat (40) @(posedge clock);
        @(negedge clock);
        checks++;
        if (aborted_cnt !== 1) begin
            errors++;
            $display("FAIL %s aborted_pulses got %0d exp 1", name, aborted_cnt);
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL %s done_count got %0d exp 0", name, done_cnt);
        end
        checks++;
        if (wr_code.size() !== exp_writes) begin
            errors++;
            $display("FAIL %s writes got %0d exp %0d", name, wr_code.size(), exp_writes);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy got %b exp 0", name, busy_o);
        end
    endtask

    task automatic test_abort();
        clear_log();
        abort_pulse();
        repeat (3) @(posedge clock);
        checks++;
        if (aborted_cnt !== 0) begin
            errors++;
            $display("FAIL abort_idle aborted_pulses got %0d exp 0", aborted_cnt);
        end
        clear_log();
        pulse_start(20);
        wait_writes("abort_settle", 2 * WPS + 1);
        repeat (2) @(posedge clock);
        abort_pulse();
        check_abort("abort_settle", 2 * WPS + 1);
        clear_log();
        pulse_start(20);
        while (cyc < start_cyc + LAT - 2) @(posedge clock);
        #1;
        abort_i = 1'b1;
        @(posedge clock); #1;
        abort_i = 1'b0;
        check_abort("abort_last_commit", N * WPS - 1);
    endtask
`endif

    initial begin
        for (int s = 0; s < N; s++) bank[s] = '0;
        test_reset();
        run_and_check("single_run", 20, 0, -1, 1'b0, 1'b0);
        run_and_check("target_zero", 0, 0, -1, 1'b0, 1'b0);
        run_and_check("target_max", 127, 0, -1, 1'b0, 1'b0);
        run_and_check("forced_fail", 10, 0, 2, 1'b0, 1'b0);
        run_and_check("vld_toggle", 20, 1, -1, 1'b1, 1'b0);
        run_and_check("restart_ignored", 20, 0, -1, 1'b0, 1'b1);
        test_reset_mid_run();
        run_and_check("after_reset", 20, 0, -1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_and_check("random", int'($urandom_range(0, 127)), 2, -1, 1'b1, 1'b0);
`ifdef TDC_CALIB_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
